a51_keystream_ctrl: RTL and testbench
=====================================

// Module: a51_keystream_ctrl
// PURPOSE
//   Sequencer for the three A5/1 LFSRs (X 19b, Y 22b, Z 23b). On start it pulses load
//   into all three registers, then runs WARMUP_CYCLES majority-clocked steps with the
//   output discarded. It then produces len_bytes keystream bytes, MSB first, each from
//   8 majority-clocked steps. Bytes go to the image XOR stage over a valid/ready handshake.
// PARAMETERS
//   WARMUP_CYCLES  100  discarded majority-clocked steps after load (>=1)
//   LEN_W          16   width of len_bytes and the byte counter
// PORTS
//   clk        in   1      system clock, all state updates on posedge
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      begin a session; sampled only in IDLE
//   abort      in   1      synchronous abort; returns to IDLE next edge from any state
//   len_bytes  in   LEN_W  keystream bytes to produce; captured in the start cycle
//   x_maj      in   1      X clocking bit (X[8])
//   y_maj      in   1      Y clocking bit (Y[10])
//   z_maj      in   1      Z clocking bit (Z[10])
//   x_out      in   1      X MSB (X[18])
//   y_out      in   1      Y MSB (Y[21])
//   z_out      in   1      Z MSB (Z[22])
//   load       out  1      all three registers load key this cycle
//   trig_x     out  1      step X this cycle
//   trig_y     out  1      step Y this cycle
//   trig_z     out  1      step Z this cycle
//   ks_byte    out  8      keystream byte, stable while ks_valid=1
//   ks_valid   out  1      ks_byte available
//   ks_ready   in   1      consumer accepts; transfer when ks_valid & ks_ready at posedge
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse after the last byte transfers
// BEHAVIOUR
//   States: IDLE, LOAD, WARMUP, RUN, HOLD, DONE. The state register is reset by rst_n.
//   Reset values: state=IDLE, ks_byte=8'h00, ks_valid=0, done=0, counters=0.
//     load, trig_* and busy are decoded from state, so they are 0 in reset.
//   IDLE: when start=1, capture len_bytes and go to LOAD.
//   LOAD: one cycle. load=1, trig_*=0. Go to WARMUP.
//   WARMUP: exactly WARMUP_CYCLES cycles, each a majority step. Output bits are ignored.
//     At the end, go to DONE if the captured len=0, otherwise go to RUN.
//   Majority step (WARMUP and RUN only, combinational from the current maj inputs):
//     m = (x_maj&y_maj)|(x_maj&z_maj)|(y_maj&z_maj)
//     trig_x = (x_maj==m), trig_y = (y_maj==m), trig_z = (z_maj==m)
//     At least two triggers are always high.
//   RUN: 8 cycles. Each cycle, bit = x_out^y_out^z_out (the pre-step register state),
//     shifted in as shreg = {shreg[6:0], bit}, and the step is applied that same cycle.
//     On the 8th cycle: ks_byte <= {shreg[6:0], bit}, ks_valid <= 1, go to HOLD.
//   HOLD: trig_*=0, so the LFSRs are frozen. ks_byte and ks_valid are held for any
//     number of cycles. On ks_valid & ks_ready, ks_valid <= 0 and the remaining count
//     is decremented. Go to RUN if bytes remain, otherwise go to DONE.
//     A ready already high when valid rises completes the transfer on that first cycle.
//   DONE: one cycle. done=1, busy=1. Go to IDLE.
//   Latency: start sampled at edge 0 gives load=1 in cycle 1.
//     First ks_valid rises at edge WARMUP_CYCLES+10, with minimum byte spacing of 9 cycles.
//   start while busy: ignored. len_bytes changes after capture: ignored.
//   abort: takes priority over every transition. Next edge: IDLE, ks_valid=0, no done pulse.
//     A pending byte is dropped and ks_byte keeps its last value.
//   Reset mid-operation: asynchronous return to IDLE with all outputs at reset values.
//     The LFSR contents are not restored; the next start reloads them.
//   The byte counter never wraps. The maximum length is 2^LEN_W-1 bytes.
// TESTING
//   Reset: rst_n=0 mid-RUN -> within the same cycle, ks_valid=0, load=0, trig_*=0, busy=0.
//   Majority in WARMUP: x_maj=1, y_maj=0, z_maj=1 -> trig_x=1, trig_y=0, trig_z=1.
//     Also x,y,z=0,0,0 -> all three triggers=1.
//   Zero key, len_bytes=3, ks_ready=1 -> three bytes 8'h00, 9 cycles apart.
//     First byte at edge 110, then a done pulse.
//   Known key against the golden A5/1 model, len_bytes=4 -> bytes match the model
//     bit-exact, MSB first.
//   Backpressure: ks_ready=0 for 20 cycles in HOLD -> ks_byte constant, trig_*=0, no
//     register drift. Next byte still matches the model.
//   len_bytes=0 -> load pulse, 100 warmup steps, done at edge 102, ks_valid never high.
//     Then abort mid-RUN -> IDLE next edge, no done; a new start reproduces byte 0.

Source files
------------

// File: rtl/a51_keystream_ctrl.sv
// a51_keystream_ctrl: A5/1 LFSR sequencer (load, warmup, keystream bytes over valid/ready)
//   clk, rst_n            clock, async active-low reset
//   start, abort          session start (IDLE only) / synchronous abort to IDLE
//   len_bytes             keystream byte count, captured with start
//   x/y/z_maj, x/y/z_out  LFSR clocking bits and MSBs
//   load, trig_x/y/z      LFSR key load and per-register step strobes
//   ks_byte, ks_valid     keystream byte handshake with ks_ready
//   busy, done            session active / one-cycle completion pulse
module a51_keystream_ctrl #(
  parameter int WARMUP_CYCLES = 100,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len_bytes,
  input  logic             x_maj,
  input  logic             y_maj,
  input  logic             z_maj,
  input  logic             x_out,
  input  logic             y_out,
  input  logic             z_out,
  output logic             load,
  output logic             trig_x,
  output logic             trig_y,
  output logic             trig_z,
  output logic [7:0]       ks_byte,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done
);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WW-1:0] W_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  typedef enum logic [2:0] {IDLE, LOAD, WARMUP, RUN, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] byte_q, byte_d;
  logic valid_q, valid_d;
  logic m, ks_bit, step;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      warm_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      byte_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      warm_q <= warm_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      byte_q <= byte_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    warm_d = warm_q;
    bit_d = bit_q;
    shreg_d = shreg_q;
    byte_d = byte_q;
    valid_d = valid_q;
    m = (x_maj & y_maj) | (x_maj & z_maj) | (y_maj & z_maj);
    ks_bit = x_out ^ y_out ^ z_out;
    step = (state_q == WARMUP) || (state_q == RUN);
    case (state_q)
      IDLE: begin
        len_d = start ? len_bytes : len_q;
        state_d = start ? LOAD : IDLE;
      end
      LOAD: begin
        warm_d = '0;
        bit_d = '0;
        state_d = WARMUP;
      end
      WARMUP: begin
        warm_d = warm_q + WW'(1);
        state_d = (warm_q != W_LAST) ? WARMUP : (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        shreg_d = {shreg_q[5:0], ks_bit};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_d = {shreg_q, ks_bit};
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ks_ready) begin
          valid_d = 1'b0;
          len_d = len_q - ONE;
          state_d = (len_q == ONE) ? DONE : RUN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort overrides every transition; the held byte value is kept, only valid drops
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  assign load = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign trig_x = step && (x_maj == m);
  assign trig_y = step && (y_maj == m);
  assign trig_z = step && (z_maj == m);
  assign ks_byte = byte_q;
  assign ks_valid = valid_q;
endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// tb_a51_keystream_ctrl: directed bench with A5/1 register environment and golden keystream model
module tb_a51_keystream_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [15:0] len_bytes = '0;
  logic ks_ready = 1'b0;
  logic load, trig_x, trig_y, trig_z, ks_valid, busy, done;
  logic [7:0] ks_byte;
  logic x_maj, y_maj, z_maj, x_out, y_out, z_out;
  logic [18:0] rx, kx;
  logic [21:0] ry, ky;
  logic [22:0] rz, kz;
  logic ovr = 1'b0;
  logic fx = 1'b0, fy = 1'b0, fz = 1'b0;
  logic [7:0] gold [8];
  int vc [8];
  logic [7:0] vb [8];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  a51_keystream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len_bytes(len_bytes),
    .x_maj(x_maj), .y_maj(y_maj), .z_maj(z_maj), .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .load(load), .trig_x(trig_x), .trig_y(trig_y), .trig_z(trig_z),
    .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy), .done(done)
  );
  assign x_maj = ovr ? fx : rx[8];
  assign y_maj = ovr ? fy : ry[10];
  assign z_maj = ovr ? fz : rz[10];
  assign x_out = rx[18];
  assign y_out = ry[21];
  assign z_out = rz[22];
  always_ff @(posedge clk) begin
    if (load) begin
      rx <= kx;
      ry <= ky;
      rz <= kz;
    end else begin
      if (trig_x) rx <= {rx[17:0], rx[18] ^ rx[17] ^ rx[16] ^ rx[13]};
      if (trig_y) ry <= {ry[20:0], ry[21] ^ ry[20]};
      if (trig_z) rz <= {rz[21:0], rz[22] ^ rz[21] ^ rz[20] ^ rz[7]};
    end
  end
  task automatic compute_gold(input int n);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic mj, bt;
    a = kx; b = ky; c = kz;
    for (int i = 0; i < 100 + 8 * n; i++) begin
      bt = a[18] ^ b[21] ^ c[22];
      mj = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
      if (a[8] == mj) a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
      if (b[10] == mj) b = {b[20:0], b[21] ^ b[20]};
      if (c[10] == mj) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
      if (i >= 100) gold[(i - 100) / 8] = {gold[(i - 100) / 8][6:0], bt};
    end
  endtask
  task automatic start_session(input logic [15:0] len);
    @(negedge clk);
    start = 1'b1;
    len_bytes = len;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if ({load, trig_x, trig_y, trig_z, ks_valid, busy, done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {load, trig_x, trig_y, trig_z, ks_valid, busy, done});
    end
    checks++;
    if (ks_byte !== 8'h00) begin
      failures++;
      $display("FAIL reset_byte got=%h exp=00", ks_byte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_majority;
    kx = '0; ky = '0; kz = '0;
    start_session(16'd1);
    checks++;
    if ({load, trig_x, trig_y, trig_z, busy} !== 5'b10001) begin
      failures++;
      $display("FAIL load_cycle got=%b exp=10001", {load, trig_x, trig_y, trig_z, busy});
    end
    repeat (4) @(negedge clk);
    ovr = 1'b1; fx = 1'b1; fy = 1'b0; fz = 1'b1;
    #1;
    checks++;
    if ({trig_x, trig_y, trig_z} !== 3'b101) begin
      failures++;
      $display("FAIL maj_101 got=%b exp=101", {trig_x, trig_y, trig_z});
    end
    fx = 1'b0; fz = 1'b0;
    #1;
    checks++;
    if ({trig_x, trig_y, trig_z} !== 3'b111) begin
      failures++;
      $display("FAIL maj_000 got=%b exp=111", {trig_x, trig_y, trig_z});
    end
    fx = 1'b0; fy = 1'b1; fz = 1'b1;
    #1;
    checks++;
    if ({trig_x, trig_y, trig_z} !== 3'b011) begin
      failures++;
      $display("FAIL maj_011 got=%b exp=011", {trig_x, trig_y, trig_z});
    end
    ovr = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, ks_valid} !== 3'b000) begin
      failures++;
      $display("FAIL abort_warmup got=%b exp=000", {busy, done, ks_valid});
    end
  endtask
  task automatic test_zero_key;
    int nv, dc;
    kx = '0; ky = '0; kz = '0;
    ks_ready = 1'b1;
    nv = 0; dc = -1;
    start_session(16'd3);
    for (int c = 1; c <= 140; c++) begin
      if (ks_valid) begin
        if (nv < 8) begin
          vc[nv] = c;
          vb[nv] = ks_byte;
        end
        nv++;
      end
      if (done) dc = c;
      @(negedge clk);
    end
    checks++;
    if (nv != 3) begin
      failures++;
      $display("FAIL zero_count got=%0d exp=3", nv);
    end
    for (int i = 0; i < 3 && i < nv; i++) begin
      checks++;
      if (vc[i] != 110 + 9 * i || vb[i] !== 8'h00) begin
        failures++;
        $display("FAIL zero_byte%0d got=cycle %0d byte %h exp=cycle %0d byte 00", i, vc[i], vb[i], 110 + 9 * i);
      end
    end
    checks++;
    if (dc != 129) begin
      failures++;
      $display("FAIL zero_done got=%0d exp=129", dc);
    end
  endtask
  task automatic test_known_key;
    int nv, dc;
    kx = 19'h5A3C1; ky = 22'h2B7E15; kz = 23'h1F0A5C;
    compute_gold(4);
    ks_ready = 1'b1;
    nv = 0; dc = -1;
    start_session(16'd4);
    for (int c = 1; c <= 150; c++) begin
      if (ks_valid) begin
        if (nv < 8) begin
          vc[nv] = c;
          vb[nv] = ks_byte;
        end
        nv++;
      end
      if (done) dc = c;
      @(negedge clk);
    end
    checks++;
    if (nv != 4) begin
      failures++;
      $display("FAIL key_count got=%0d exp=4", nv);
    end
    for (int i = 0; i < 4 && i < nv; i++) begin
      checks++;
      if (vc[i] != 110 + 9 * i || vb[i] !== gold[i]) begin
        failures++;
        $display("FAIL key_byte%0d got=cycle %0d byte %h exp=cycle %0d byte %h", i, vc[i], vb[i], 110 + 9 * i, gold[i]);
      end
    end
    checks++;
    if (dc != 138) begin
      failures++;
      $display("FAIL key_done got=%0d exp=138", dc);
    end
  endtask
  task automatic test_backpressure;
    logic [7:0] b0;
    logic [63:0] regs;
    int w;
    bit drift;
    kx = 19'h5A3C1; ky = 22'h2B7E15; kz = 23'h1F0A5C;
    compute_gold(2);
    ks_ready = 1'b0;
    start_session(16'd2);
    w = 0;
    while (!ks_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!ks_valid || ks_byte !== gold[0]) begin
      failures++;
      $display("FAIL bp_byte0 got=valid %b byte %h exp=valid 1 byte %h", ks_valid, ks_byte, gold[0]);
    end
    b0 = ks_byte;
    regs = {rx, ry, rz};
    drift = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ks_byte !== b0 || !ks_valid || {trig_x, trig_y, trig_z} !== 3'b000) drift = 1'b1;
    end
    checks++;
    if (drift || {rx, ry, rz} !== regs) begin
      failures++;
      $display("FAIL bp_hold got=regs %h byte %h exp=regs %h byte %h", {rx, ry, rz}, ks_byte, regs, b0);
    end
    ks_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ks_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got=valid %b exp=valid 0", ks_valid);
    end
    w = 0;
    while (!ks_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!ks_valid || ks_byte !== gold[1] || w != 8) begin
      failures++;
      $display("FAIL bp_byte1 got=valid %b byte %h wait %0d exp=valid 1 byte %h wait 8", ks_valid, ks_byte, w, gold[1]);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_len0_abort;
    int steps, lc, dc, nv;
    kx = 19'h5A3C1; ky = 22'h2B7E15; kz = 23'h1F0A5C;
    compute_gold(1);
    ks_ready = 1'b1;
    steps = 0; lc = 0; dc = -1; nv = 0;
    start_session(16'd0);
    for (int c = 1; c <= 110; c++) begin
      if (load) lc = lc + c;
      if (trig_x | trig_y | trig_z) steps++;
      if (done) dc = c;
      if (ks_valid) nv++;
      @(negedge clk);
    end
    checks++;
    if (lc != 1 || steps != 100) begin
      failures++;
      $display("FAIL len0_steps got=load %0d steps %0d exp=load 1 steps 100", lc, steps);
    end
    checks++;
    if (dc != 102 || nv != 0) begin
      failures++;
      $display("FAIL len0_done got=done %0d valid %0d exp=done 102 valid 0", dc, nv);
    end
    start_session(16'd2);
    repeat (104) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    dc = 0;
    for (int c = 0; c < 5; c++) begin
      if (done | busy | ks_valid) dc++;
      @(negedge clk);
    end
    checks++;
    if (dc != 0) begin
      failures++;
      $display("FAIL abort_run got=%0d active cycles exp=0", dc);
    end
    start_session(16'd1);
    nv = 0;
    for (int c = 1; c <= 115; c++) begin
      if (ks_valid && nv == 0) begin
        vc[0] = c;
        vb[0] = ks_byte;
        nv = 1;
      end
      @(negedge clk);
    end
    checks++;
    if (nv != 1 || vc[0] != 110 || vb[0] !== gold[0]) begin
      failures++;
      $display("FAIL restart_byte got=cycle %0d byte %h exp=cycle 110 byte %h", vc[0], vb[0], gold[0]);
    end
  endtask
  task automatic test_reset_mid_run;
    kx = 19'h5A3C1; ky = 22'h2B7E15; kz = 23'h1F0A5C;
    ks_ready = 1'b1;
    start_session(16'd2);
    repeat (104) @(negedge clk);
    checks++;
    if (!busy || (trig_x + trig_y + trig_z) < 2) begin
      failures++;
      $display("FAIL run_active got=busy %b trig %b exp=busy 1 two+ trig", busy, {trig_x, trig_y, trig_z});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ks_valid, load, trig_x, trig_y, trig_z, busy, done} !== 7'b0 || ks_byte !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_run got=%b byte %h exp=0000000 byte 00", {ks_valid, load, trig_x, trig_y, trig_z, busy, done}, ks_byte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    kx = '0; ky = '0; kz = '0;
    test_reset;
    test_majority;
    test_zero_key;
    test_known_key;
    test_backpressure;
    test_len0_abort;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
